// File: rtl/dlart_mux.sv
// Multi-channel DL11-compatible serial line block: per-channel RX/TX byte FIFOs
// behind the standard RCSR/RBUF/XCSR/XBUF register window, with host byte streams.
module dlart_mux #(
  parameter int          NCH   = 1,
  parameter int          DEPTH = 4,
  parameter logic [21:0] BASE  = 22'o17777560
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [21:0]          bus_addr,
  input  logic                 bus_rd,
  input  logic                 bus_wr,
  input  logic                 bus_byte,
  input  logic [15:0]          bus_wdata,
  output logic [15:0]          bus_rdata,
  output logic                 bus_hit,
  output logic [NCH-1:0]       irq_rx,
  output logic [NCH-1:0]       irq_tx,
  input  logic [NCH-1:0]       h_rx_valid,
  input  logic [8*NCH-1:0]     h_rx_data,
  output logic [NCH-1:0]       h_rx_ready,
  output logic [NCH-1:0]       h_tx_valid,
  output logic [8*NCH-1:0]     h_tx_data,
  input  logic [NCH-1:0]       h_tx_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]          off;
  logic                wr_lo;
  logic                wr_hi;
  logic [NCH-1:0]      sel;
  logic [16*NCH-1:0]   rd_flat;
  logic [15:0]         rd_mux;
  logic                unused_wdata;

  assign off          = bus_addr[2:1];
  // byte writes carry their lane in bus_addr[0]; word writes hit both lanes
  assign wr_lo        = bus_wr & (~bus_byte | ~bus_addr[0]);
  assign wr_hi        = bus_wr & (~bus_byte | bus_addr[0]);
  assign bus_hit      = |sel;
  assign unused_wdata = ^{bus_wdata[14:8], bus_wdata[5:1]};

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [18:0] WIN = BASE[21:3] + 19'(k);

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic          rie, tie, brk, txovr;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic          rx_push, rx_pop, tx_push, tx_pop, tx_drop, xbuf_wr;
    logic [15:0]   rd_v;

    assign sel[k]    = (bus_addr[21:3] == WIN);
    assign rx_full   = (rx_cnt == FULL_CNT);
    assign rx_empty  = (rx_cnt == '0);
    assign tx_full   = (tx_cnt == FULL_CNT);
    assign tx_empty  = (tx_cnt == '0);

    assign h_rx_ready[k]         = rstb & ~rx_full;
    assign h_tx_valid[k]         = rstb & ~tx_empty & ~brk;
    assign h_tx_data[8*k +: 8]   = tx_mem[tx_rp];
    assign irq_rx[k]             = rstb & rie & ~rx_empty;
    assign irq_tx[k]             = rstb & tie & ~tx_full;

    // full/empty are pre-edge, so a pop on full blocks the push and vice versa
    assign rx_push = h_rx_valid[k] & h_rx_ready[k];
    assign rx_pop  = rstb & bus_rd & sel[k] & (off == 2'd1) & ~rx_empty;
    assign xbuf_wr = rstb & wr_lo & sel[k] & (off == 2'd3);
    assign tx_push = xbuf_wr & ~tx_full;
    assign tx_drop = xbuf_wr & tx_full;
    assign tx_pop  = h_tx_valid[k] & h_tx_ready[k];

    always_comb begin
      case (off)
        2'd0:    rd_v = {8'b0, ~rx_empty, rie, 6'b0};
        2'd1:    rd_v = {8'b0, rx_empty ? 8'h00 : rx_mem[rx_rp]};
        2'd2:    rd_v = {txovr, 7'b0, ~tx_full, tie, 5'b0, brk};
        default: rd_v = '0;
      endcase
    end
    assign rd_flat[16*k +: 16] = rd_v;

    always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp] <= h_rx_data[8*k +: 8];
      if (tx_push) tx_mem[tx_wp] <= bus_wdata[7:0];
    end

    always_ff @(posedge clk) begin
      if (!rstb) begin
        rx_wp  <= '0;
        rx_rp  <= '0;
        rx_cnt <= '0;
        tx_wp  <= '0;
        tx_rp  <= '0;
        tx_cnt <= '0;
        rie    <= 1'b0;
        tie    <= 1'b0;
        brk    <= 1'b0;
        txovr  <= 1'b0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + AW'(1);
        if (rx_pop)  rx_rp <= rx_rp + AW'(1);
        rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        if (tx_push) tx_wp <= tx_wp + AW'(1);
        if (tx_pop)  tx_rp <= tx_rp + AW'(1);
        tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
        if (wr_lo && sel[k] && off == 2'd0) rie <= bus_wdata[6];
        if (wr_lo && sel[k] && off == 2'd2) begin
          tie <= bus_wdata[6];
          brk <= bus_wdata[0];
        end
        if (tx_drop) txovr <= 1'b1;
        else if (wr_hi && sel[k] && off == 2'd2 && bus_wdata[15]) txovr <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel[k]) rd_mux = rd_flat[16*k +: 16];
    end
  end

  // misses leave bus_rdata untouched so the last value holds
  always_ff @(posedge clk) begin
    if (!rstb) bus_rdata <= '0;
    else if (bus_rd && bus_hit) bus_rdata <= rd_mux;
  end
endmodule

// File: doc/dlart_mux.md
DLART_MUX -- requirements
Module: dlart_mux

Interface
REQ-001 SHALL have parameter NCH, default 1: number of DL11-compatible channels, range 1..8.
REQ-002 SHALL have parameter DEPTH, default 4: entries per RX and per TX FIFO, power of 2, range 2..16.
REQ-003 SHALL have parameter BASE, default 22'o17777560: channel 0 register base; channel k base = BASE + 8*k.
REQ-004 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rstb  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port bus_addr  in  22  latched physical byte address.
REQ-007 SHALL have ports bus_rd / bus_wr  in  1 each  one-cycle read / write strobes.
REQ-008 SHALL have port bus_byte  in  1  byte write; bus_addr[0] selects the high byte.
REQ-009 SHALL have port bus_wdata  in  16  write data.
REQ-010 SHALL have port bus_rdata  out  16  registered read data.
REQ-011 SHALL have port bus_hit  out  1  combinational: bus_addr[21:3] matches any channel window; used for NXM suppression.
REQ-012 SHALL have ports irq_rx / irq_tx  out  NCH each  level interrupt requests.
REQ-013 SHALL have ports h_rx_valid  in  NCH,  h_rx_data  in  8*NCH,  h_rx_ready  out  NCH  for host-to-CPU bytes.
REQ-014 SHALL have ports h_tx_valid  out  NCH,  h_tx_data  out  8*NCH,  h_tx_ready  in  NCH  for CPU-to-host bytes.

Function
REQ-015 SHALL decode word offsets per channel: 0 RCSR, 2 RBUF, 4 XCSR, 6 XBUF.
REQ-016 SHALL read RCSR as bit7 DONE (RX FIFO non-empty) and bit6 RIE; all other bits read 0.
REQ-017 SHALL read RBUF as {8'b0, RX head}; a read with RX FIFO non-empty pops one entry; a read with RX FIFO empty returns 0 and pops nothing.
REQ-018 SHALL read XCSR as bit15 TXOVR, bit7 READY (TX FIFO not full), bit6 TIE and bit0 BREAK; all other bits read 0.
REQ-019 SHALL read XBUF as 0.
REQ-020 SHALL return bus_rdata one cycle after bus_rd; the pop occurs on that same edge; bus_rdata holds its value until the next read.
REQ-021 SHALL implement CSR writes as follows:
- a low byte or word write updates RIE/TIE from bit6 and BREAK from bit0;
- a high byte or word write with bit15=1 clears TXOVR;
- all other bits are ignored.
REQ-022 SHALL push bus_wdata[7:0] on a word write, or a low byte write, to XBUF while the TX FIFO is not full.
REQ-023 SHALL drop an XBUF write made while the TX FIFO is full and set TXOVR; TXOVR is sticky.
REQ-024 SHALL ignore writes to RBUF and high byte writes to XBUF.
REQ-025 SHALL drive h_rx_ready[k] = RX FIFO k not full; a push occurs on h_rx_valid & h_rx_ready.
REQ-026 SHALL drive h_tx_valid[k] = TX FIFO k non-empty & !BREAK[k], with h_tx_data = TX head; a pop occurs on h_tx_valid & h_tx_ready.
REQ-027 SHALL evaluate full and empty before the edge:
- on a full FIFO, a simultaneous push and pop performs only the pop;
- on an empty FIFO, a simultaneous push and pop performs only the push;
- otherwise both occur and count is unchanged.
REQ-028 SHALL use pointers of clog2(DEPTH) bits that wrap modulo DEPTH, with a count of clog2(DEPTH)+1 bits ranging 0..DEPTH.
REQ-029 SHALL drive irq_rx[k] = RIE & DONE and irq_tx[k] = TIE & READY, from registered state.
REQ-030 SHALL keep channels independent; bus_hit=0 means no register side effects.

Reset
REQ-031 SHALL, while rstb=0, empty all FIFOs and zero pointers, RIE, TIE, BREAK, TXOVR and bus_rdata.
REQ-032 SHALL, while rstb=0, hold h_rx_ready=0, h_tx_valid=0 and irq_*=0.
REQ-033 SHALL make reset asserted mid-transfer discard FIFO contents, with no partial handshake completing on that edge.

Verification
REQ-034 Reset, NCH=2 -> RCSR=0, XCSR=0o200; h_rx_ready=2'b11; bus_hit=1 at 17777570 and 0 at 17777600.
REQ-035 Host pushes 0x41,0x42 on ch0; RCSR=0o200; two RBUF reads -> 0x41 then 0x42, each one cycle after bus_rd; RCSR=0; a third read returns 0.
REQ-036 DEPTH=4: five XBUF writes with h_tx_ready=0 -> READY=0 after the fourth, fifth dropped, XCSR=0o100000; write 0o100000 to XCSR -> TXOVR=0.
REQ-037 TX full with a simultaneous XBUF write and host pop -> one entry drained, write dropped, count=3, TXOVR=1.
REQ-038 Set BREAK with data queued -> h_tx_valid=0; clear BREAK -> bytes delivered in order; TIE=1 and not full -> irq_tx=1.
REQ-039 Host pushes 4 bytes while the CPU pops concurrently, crossing the pointer wrap -> no loss, order preserved; rstb low mid-stream -> all FIFOs empty next cycle.
